// File: rtl/c5_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: function codes and
// elaboration helpers that place the stage registers between shift levels.
package c5_shifter_pipe_pkg;

  typedef enum logic [2:0] {
    SHIFT_LEFT_UNSIGNED  = 3'b000,
    SHIFT_RIGHT_UNSIGNED = 3'b001,
    SHIFT_RIGHT_SIGNED   = 3'b010,
    SHIFT_ROTATE_RIGHT   = 3'b011,
    SHIFT_ROTATE_LEFT    = 3'b100,
    SHIFT_ZERO           = 3'b101
  } shift_func_t;

  localparam int SHIFT_FUNC_W = 3;

  // Older 2-bit function fields map onto the 3-bit space by zero-extension.
  function automatic logic [SHIFT_FUNC_W-1:0] shift_func_from_legacy(input logic [1:0] f);
    return {1'b0, f};
  endfunction

  function automatic logic func_is_shift(input logic [SHIFT_FUNC_W-1:0] f);
    return f <= SHIFT_ROTATE_LEFT;
  endfunction

  // Stage index whose register follows level lvl, or -1 if the level is combinational.
  function automatic int reg_stage(input int lvl, input int shw, input int stages);
    int r;
    r = -1;
    for (int s = 0; s < stages; s++) begin
      if ((s + 1) * shw / stages - 1 == lvl) r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/c5_shifter_pipe_if.sv
// Request/response bundle of the shifter: issue side, result side and flush.
interface c5_shifter_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic                 I_flush;
  logic                 I_valid;
  logic                 O_ready;
  logic [WIDTH-1:0]     I_value;
  logic [SHW-1:0]       I_shift_amount;
  logic [2:0]           I_shift_func;
  logic [TAG_WIDTH-1:0] I_tag;
  logic                 O_valid;
  logic                 I_ready;
  logic [WIDTH-1:0]     O_result;
  logic [TAG_WIDTH-1:0] O_tag;
  logic                 O_busy;

  modport master (
    output I_flush, I_valid, I_value, I_shift_amount, I_shift_func, I_tag, I_ready,
    input  O_ready, O_valid, O_result, O_tag, O_busy
  );

  modport slave (
    input  I_flush, I_valid, I_value, I_shift_amount, I_shift_func, I_tag, I_ready,
    output O_ready, O_valid, O_result, O_tag, O_busy
  );
endinterface

// File: rtl/c5_shift_level.sv
// One log-shifter level: conditionally shifts or rotates by a fixed DIST bits.
module c5_shift_level
  import c5_shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       func,
  input  logic             en,
  input  logic             fill,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    if (en) begin
      case (func)
        SHIFT_LEFT_UNSIGNED:  dout = {din[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SHIFT_RIGHT_UNSIGNED: dout = {{DIST{1'b0}}, din[WIDTH-1:DIST]};
        SHIFT_RIGHT_SIGNED:   dout = {{DIST{fill}}, din[WIDTH-1:DIST]};
        SHIFT_ROTATE_RIGHT:   dout = {din[DIST-1:0], din[WIDTH-1:DIST]};
        SHIFT_ROTATE_LEFT:    dout = {din[WIDTH-DIST-1:0], din[WIDTH-1:WIDTH-DIST]};
        default:              dout = '0;
      endcase
    end
  end

endmodule

// File: rtl/c5_shifter_pipe.sv
// Pipelined barrel shifter/rotator: SHW log-shifter levels with PIPE_STAGES
// registers spread between them, global stall and a pass-through tag.
module c5_shifter_pipe
  import c5_shifter_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 4
) (
  input  logic               I_clk,
  input  logic               I_reset_n,
  c5_shifter_pipe_if.slave   bus
);

  localparam int SHW = $clog2(WIDTH);

  logic                   advance;
  logic                   accept;
  logic [PIPE_STAGES-1:0] vld_all;

  // Every register moves together; bubbles are held rather than squeezed out.
  assign advance = !bus.O_valid || bus.I_ready;
  assign accept  = bus.I_valid && advance && !bus.I_flush;

  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    localparam int RS = reg_stage(k, SHW, PIPE_STAGES);

    logic [WIDTH-1:0]     d_in;
    logic [WIDTH-1:0]     d_lvl;
    logic [WIDTH-1:0]     d_out;
    logic [TAG_WIDTH-1:0] t_in;
    logic [TAG_WIDTH-1:0] t_out;
    logic                 v_in;
    logic                 v_out;
    logic [2:0]           f_in;
    logic                 fill_in;
    logic [SHW-1:k]       a_in;

    if (k == 0) begin : g_src
      // Unsupported codes become a zero operand shifted left: the result is 0.
      assign d_in    = func_is_shift(bus.I_shift_func) ? bus.I_value : '0;
      assign f_in    = func_is_shift(bus.I_shift_func) ? bus.I_shift_func : 3'(SHIFT_LEFT_UNSIGNED);
      assign fill_in = bus.I_value[WIDTH-1];
      assign a_in    = bus.I_shift_amount;
      assign t_in    = bus.I_tag;
      assign v_in    = accept;
    end else begin : g_chain
      assign d_in    = g_lvl[k-1].d_out;
      assign f_in    = g_lvl[k-1].g_side.f_out;
      assign fill_in = g_lvl[k-1].g_side.fill_out;
      assign a_in    = g_lvl[k-1].g_side.a_out;
      assign t_in    = g_lvl[k-1].t_out;
      assign v_in    = g_lvl[k-1].v_out;
    end

    c5_shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_level (
      .din  (d_in),
      .func (f_in),
      .en   (a_in[k]),
      .fill (fill_in),
      .dout (d_lvl)
    );

    if (RS < 0) begin : g_comb
      assign d_out = d_lvl;
      assign t_out = t_in;
      assign v_out = v_in;
    end else begin : g_reg
      // ---- stage register RS: after level k ----
      always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n)       v_out <= 1'b0;
        else if (bus.I_flush) v_out <= 1'b0;
        else if (advance)     v_out <= v_in;
      end

      always_ff @(posedge I_clk) begin
        if (advance) begin
          d_out <= d_lvl;
          t_out <= t_in;
        end
      end

      assign vld_all[RS] = v_out;
    end

    // Function, fill and the not-yet-used amount bits ride along to later levels.
    if (k < SHW - 1) begin : g_side
      logic [2:0]       f_out;
      logic             fill_out;
      logic [SHW-1:k+1] a_out;

      if (RS < 0) begin : g_comb
        assign f_out    = f_in;
        assign fill_out = fill_in;
        assign a_out    = a_in[SHW-1:k+1];
      end else begin : g_reg
        always_ff @(posedge I_clk) begin
          if (advance) begin
            f_out    <= f_in;
            fill_out <= fill_in;
            a_out    <= a_in[SHW-1:k+1];
          end
        end
      end
    end
  end

  assign bus.O_valid  = g_lvl[SHW-1].v_out;
  assign bus.O_result = bus.O_valid ? g_lvl[SHW-1].d_out : '0;
  assign bus.O_tag    = bus.O_valid ? g_lvl[SHW-1].t_out : '0;
  assign bus.O_busy   = |vld_all;
  assign bus.O_ready  = advance && !bus.I_flush;

endmodule

// File: tb/tb_c5_shifter_pipe.sv
// Bench for c5_shifter_pipe: directed cases on a 32-bit/2-stage and an
// 8-bit/3-stage instance plus randomized traffic against a reference model.
module tb_c5_shifter_pipe;
  import c5_shifter_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  c5_shifter_pipe_if #(.WIDTH(32), .TAG_WIDTH(4)) b32 ();
  c5_shifter_pipe_if #(.WIDTH(8),  .TAG_WIDTH(4)) b8 ();

  c5_shifter_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_WIDTH(4)) dut32 (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .bus       (b32)
  );

  c5_shifter_pipe #(.WIDTH(8), .PIPE_STAGES(3), .TAG_WIDTH(4)) dut8 (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .bus       (b8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shift/rotate computed arithmetically on a w-bit value held in 64 bits.
  function automatic logic [63:0] ref_shift(input int w, input logic [63:0] v,
                                            input int amt, input logic [2:0] f);
    logic [63:0] m;
    logic [63:0] x;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = v & m;
    case (f)
      3'd0:    return (x << amt) & m;
      3'd1:    return x >> amt;
      3'd2:    return x[w-1] ? ((x >> amt) | (m & ~(m >> amt))) : (x >> amt);
      3'd3:    return ((x >> amt) | (x << (w - amt))) & m;
      3'd4:    return ((x << amt) | (x >> (w - amt))) & m;
      default: return 64'd0;
    endcase
  endfunction

  logic [63:0] q32_res[$];
  logic [3:0]  q32_tag[$];
  logic [63:0] q8_res[$];
  logic [3:0]  q8_tag[$];

  // Scoreboards: expectations queued on acceptance, matched in order on consumption.
  always @(negedge clk) begin
    if (!rst_n || b32.I_flush) begin
      q32_res.delete();
      q32_tag.delete();
    end else begin
      if (b32.O_valid && b32.I_ready) begin
        chk("sb32 pending", 64'(q32_res.size() > 0), 64'd1);
        if (q32_res.size() > 0) begin
          chk("sb32 result", 64'(b32.O_result), q32_res.pop_front());
          chk("sb32 tag", 64'(b32.O_tag), 64'(q32_tag.pop_front()));
        end
      end
      if (!b32.O_valid) chk("sb32 idle zero", 64'({b32.O_result, b32.O_tag}), 64'd0);
      if (b32.I_valid && b32.O_ready) begin
        q32_res.push_back(ref_shift(32, {32'd0, b32.I_value}, int'(b32.I_shift_amount), b32.I_shift_func));
        q32_tag.push_back(b32.I_tag);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n || b8.I_flush) begin
      q8_res.delete();
      q8_tag.delete();
    end else begin
      if (b8.O_valid && b8.I_ready) begin
        chk("sb8 pending", 64'(q8_res.size() > 0), 64'd1);
        if (q8_res.size() > 0) begin
          chk("sb8 result", 64'(b8.O_result), q8_res.pop_front());
          chk("sb8 tag", 64'(b8.O_tag), 64'(q8_tag.pop_front()));
        end
      end
      if (!b8.O_valid) chk("sb8 idle zero", 64'({b8.O_result, b8.O_tag}), 64'd0);
      if (b8.I_valid && b8.O_ready) begin
        q8_res.push_back(ref_shift(8, {56'd0, b8.I_value}, int'(b8.I_shift_amount), b8.I_shift_func));
        q8_tag.push_back(b8.I_tag);
      end
    end
  end

  task automatic op32(input logic [31:0] v, input int amt, input logic [2:0] f,
                      input logic [3:0] tag, input logic [31:0] exp, input string name);
    b32.I_value = v;
    b32.I_shift_amount = 5'(amt);
    b32.I_shift_func = f;
    b32.I_tag = tag;
    b32.I_valid = 1'b1;
    @(negedge clk);
    chk({name, " ready"}, 64'(b32.O_ready), 64'd1);
    @(posedge clk);
    #1 b32.I_valid = 1'b0;
    for (int i = 1; i < 2; i++) begin
      @(negedge clk);
      chk({name, " early"}, 64'(b32.O_valid), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk({name, " valid"}, 64'(b32.O_valid), 64'd1);
    chk({name, " result"}, 64'(b32.O_result), 64'(exp));
    chk({name, " tag"}, 64'(b32.O_tag), 64'(tag));
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] v, input int amt, input logic [2:0] f,
                     input logic [3:0] tag, input logic [7:0] exp, input string name);
    b8.I_value = v;
    b8.I_shift_amount = 3'(amt);
    b8.I_shift_func = f;
    b8.I_tag = tag;
    b8.I_valid = 1'b1;
    @(negedge clk);
    chk({name, " ready"}, 64'(b8.O_ready), 64'd1);
    @(posedge clk);
    #1 b8.I_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk({name, " early"}, 64'(b8.O_valid), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk({name, " valid"}, 64'(b8.O_valid), 64'd1);
    chk({name, " result"}, 64'(b8.O_result), 64'(exp));
    chk({name, " tag"}, 64'(b8.O_tag), 64'(tag));
    @(posedge clk);
    #1;
  endtask

  task automatic set32(input logic [31:0] v, input int amt, input logic [2:0] f, input logic [3:0] tag);
    b32.I_value = v;
    b32.I_shift_amount = 5'(amt);
    b32.I_shift_func = f;
    b32.I_tag = tag;
    b32.I_valid = 1'b1;
  endtask

  initial begin
    int  seen;
    bit  hold32;
    bit  hold8;
    b32.I_flush = 1'b0; b32.I_valid = 1'b0; b32.I_ready = 1'b1;
    b32.I_value = '0; b32.I_shift_amount = '0; b32.I_shift_func = '0; b32.I_tag = '0;
    b8.I_flush = 1'b0; b8.I_valid = 1'b0; b8.I_ready = 1'b1;
    b8.I_value = '0; b8.I_shift_amount = '0; b8.I_shift_func = '0; b8.I_tag = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset O_valid", 64'(b32.O_valid), 64'd0);
    chk("reset O_result", 64'(b32.O_result), 64'd0);
    chk("reset O_tag", 64'(b32.O_tag), 64'd0);
    chk("reset O_busy", 64'({b32.O_busy, b8.O_busy}), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post-reset O_ready", 64'({b32.O_ready, b8.O_ready}), 64'd3);

    op32(32'h8000_0000, 4, SHIFT_RIGHT_SIGNED, 4'h5, 32'hF800_0000, "sra32");
    op32(32'h0000_0001, 1, SHIFT_ROTATE_RIGHT, 4'h1, 32'h8000_0000, "ror32");
    op32(32'h8000_0001, 4, SHIFT_ROTATE_LEFT, 4'h2, 32'h0000_0018, "rol32");
    op32(32'hFFFF_FFFF, 31, SHIFT_RIGHT_UNSIGNED, 4'h3, 32'h0000_0001, "srl32");
    for (int f = 0; f < 5; f++) op32(32'hDEAD_BEEF, 0, 3'(f), 4'(f), 32'hDEAD_BEEF, "amt0");
    op32(32'hDEAD_BEEF, 5, 3'b111, 4'h9, 32'h0, "func7");

    // Back-to-back with the consumer stalled for three cycles.
    b32.I_ready = 1'b0;
    set32(32'h1, 0, SHIFT_LEFT_UNSIGNED, 4'h0);
    @(posedge clk); #1;
    set32(32'h1, 1, SHIFT_LEFT_UNSIGNED, 4'h1);
    @(posedge clk); #1;
    set32(32'h1, 2, SHIFT_LEFT_UNSIGNED, 4'h2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall O_ready", 64'(b32.O_ready), 64'd0);
      chk("stall O_result", 64'(b32.O_result), 64'h1);
      chk("stall O_tag", 64'(b32.O_tag), 64'h0);
      @(posedge clk); #1;
    end
    b32.I_ready = 1'b1;
    @(negedge clk);
    chk("release r0", 64'({b32.O_valid, b32.O_result}), {31'd0, 1'b1, 32'h1});
    chk("release O_ready", 64'(b32.O_ready), 64'd1);
    @(posedge clk); #1 b32.I_valid = 1'b0;
    @(negedge clk);
    chk("release r1", 64'({b32.O_valid, b32.O_tag, b32.O_result}), {27'd0, 1'b1, 4'h1, 32'h2});
    @(posedge clk);
    @(negedge clk);
    chk("release r2", 64'({b32.O_valid, b32.O_tag, b32.O_result}), {27'd0, 1'b1, 4'h2, 32'h4});
    @(posedge clk);
    @(negedge clk);
    chk("release drained", 64'(b32.O_valid), 64'd0);
    @(posedge clk); #1;

    // Flush with two ops in flight and a third request on the same cycle.
    b32.I_ready = 1'b0;
    set32(32'h10, 1, SHIFT_LEFT_UNSIGNED, 4'h7);
    @(posedge clk); #1;
    set32(32'h20, 1, SHIFT_LEFT_UNSIGNED, 4'h8);
    @(posedge clk); #1;
    set32(32'h30, 1, SHIFT_LEFT_UNSIGNED, 4'h9);
    b32.I_flush = 1'b1;
    @(negedge clk);
    chk("flush busy before", 64'(b32.O_busy), 64'd1);
    chk("flush O_ready", 64'(b32.O_ready), 64'd0);
    @(posedge clk); #1;
    b32.I_flush = 1'b0; b32.I_valid = 1'b0; b32.I_ready = 1'b1;
    @(negedge clk);
    chk("flush O_valid", 64'(b32.O_valid), 64'd0);
    chk("flush O_busy", 64'(b32.O_busy), 64'd0);
    chk("flush O_result", 64'(b32.O_result), 64'd0);
    seen = 0;
    repeat (5) begin @(posedge clk); @(negedge clk); if (b32.O_valid) seen++; end
    chk("flush no late output", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset while the output stage holds a result.
    set32(32'h3, 1, SHIFT_LEFT_UNSIGNED, 4'hA);
    @(posedge clk); #1;
    set32(32'h5, 1, SHIFT_LEFT_UNSIGNED, 4'hB);
    @(posedge clk); #1;
    b32.I_valid = 1'b0;
    #2 chk("pre-reset O_valid", 64'(b32.O_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({b32.O_valid, b32.O_busy, b32.O_tag, b32.O_result}), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after reset O_ready", 64'(b32.O_ready), 64'd1);
    seen = 0;
    repeat (5) begin @(negedge clk); if (b32.O_valid) seen++; @(posedge clk); end
    chk("reset no late output", 64'(seen), 64'd0);
    #1;

    op8(8'h80, 7, SHIFT_RIGHT_SIGNED, 4'h3, 8'hFF, "sra8");
    op8(8'h81, 1, SHIFT_ROTATE_RIGHT, 4'h4, 8'hC0, "ror8");
    op8(8'h5A, 3, 3'b110, 4'h6, 8'h00, "func6_8");

    // Randomized traffic with random back-pressure; held requests stay stable.
    hold32 = 1'b0;
    hold8 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!hold32) begin
        b32.I_valid = ($urandom_range(0, 3) != 0);
        b32.I_value = $urandom;
        b32.I_shift_amount = 5'($urandom_range(0, 31));
        b32.I_shift_func = 3'($urandom_range(0, 7));
        b32.I_tag = 4'($urandom_range(0, 15));
      end
      if (!hold8) begin
        b8.I_valid = ($urandom_range(0, 3) != 0);
        b8.I_value = 8'($urandom_range(0, 255));
        b8.I_shift_amount = 3'($urandom_range(0, 7));
        b8.I_shift_func = 3'($urandom_range(0, 7));
        b8.I_tag = 4'($urandom_range(0, 15));
      end
      b32.I_ready = ($urandom_range(0, 3) != 0);
      b8.I_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      hold32 = b32.I_valid && !b32.O_ready;
      hold8 = b8.I_valid && !b8.O_ready;
      @(posedge clk); #1;
    end

    b32.I_valid = 1'b0; b32.I_ready = 1'b1;
    b8.I_valid = 1'b0; b8.I_ready = 1'b1;
    for (int i = 0; i < 20 && (q32_res.size() != 0 || q8_res.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("drain32", 64'(q32_res.size()), 64'd0);
    chk("drain8", 64'(q8_res.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/c5_shifter_pipe.md
Name: c5_shifter_pipe

Overview:
Parametrised, pipelined barrel shifter/rotator for the execute stage and the DSP/crypto coprocessor datapaths. Supports any power-of-two WIDTH and adds rotate-left/right modes. Registered log-shifter levels are split across PIPE_STAGES, with a valid/ready handshake on both sides and a pass-through tag so the issuing unit can match results to requests.

Parameters:
WIDTH, 32, data width; power of two, 8..64
PIPE_STAGES, 2, register stages = latency in cycles; 1..log2(WIDTH)
TAG_WIDTH, 4, width of sideband tag carried with each operation
SHW (localparam), log2(WIDTH), shift-amount width

Ports:
I_clk  in  1  clock, rising edge
I_reset_n  in  1  reset, asynchronous, active-low
I_flush  in  1  synchronous flush; drops all in-flight ops
I_valid  in  1  request valid
O_ready  out  1  request accepted this cycle when I_valid && O_ready
I_value  in  WIDTH  operand
I_shift_amount  in  SHW  shift/rotate distance
I_shift_func  in  3  operation code, from shared package
I_tag  in  TAG_WIDTH  sideband, returned unchanged
O_valid  out  1  result valid
I_ready  in  1  consumer takes result when O_valid && I_ready
O_result  out  WIDTH  shifted/rotated value
O_tag  out  TAG_WIDTH  tag of this result
O_busy  out  1  OR of all stage valid bits

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valids 0. O_valid=0, O_result=0, O_tag=0, O_busy=0. O_ready=1 from the first edge after deassert.
- Function codes:
  - 000 SLL: zero fill.
  - 001 SRL: zero fill.
  - 010 SRA: fill with I_value[WIDTH-1].
  - 011 ROR, 100 ROL: wrapped bits.
  - 101..111: result = 0, still produces a valid output with tag.
- Amount 0 returns I_value unchanged for all functions 000..100.
- Datapath:
  - SHW levels; level k shifts by 2^k when amount bit k is set.
  - Function, fill bit and remaining amount bits travel with the data.
  - The stage s register (s = 0..PIPE_STAGES-1) sits after level floor((s+1)*SHW/PIPE_STAGES)-1, so the last register is always after the final level.
- Latency: an op accepted at edge n shows O_valid=1 after edge n+PIPE_STAGES when no stall occurs.
- Throughput: one op per cycle.
- Stall rule (global): advance = !O_valid || I_ready.
  - O_ready = advance.
  - When advance=0, every stage register holds, including bubbles. Bubbles are not collapsed.
- O_valid, O_result and O_tag stay stable while O_valid && !I_ready (AXI-style). Ops are never lost, duplicated or reordered.
- I_flush=1: all stage valids clear at the next edge. Any request presented the same cycle is dropped, and O_ready is forced 0 that cycle. Data registers may keep stale values.
- Reset mid-operation: all in-flight ops are discarded immediately (async).
- Simultaneous output consume and input accept in a full pipe is allowed: the pipe shifts by one.
- Invalid stages: data registers need no gating, but O_result must read 0 while O_valid=0 (output mux).

Decomposition:
- c5_parameters.v gains the 3-bit codes SHIFT_LEFT_UNSIGNED=000, SHIFT_RIGHT_UNSIGNED=001, SHIFT_RIGHT_SIGNED=010, SHIFT_ROTATE_RIGHT=011, SHIFT_ROTATE_LEFT=100, plus ZERO.
- Existing 2-bit users map through zero-extension.
- One combinational sub-module, c5_shift_level (params WIDTH, DIST): applies one conditional shift/rotate of DIST bits given func, enable and fill bit.
- c5_shifter_pipe instantiates SHW of these via generate and places the stage registers.

Test Plan:
- WIDTH=32, PIPE_STAGES=2, I_ready=1: SRA 0x80000000 by 4, tag 0x5 -> after 2 edges O_valid=1, O_result=0xF8000000, O_tag=0x5.
- Rotates: ROR 0x00000001 by 1 -> 0x80000000. ROL 0x80000001 by 4 -> 0x00000018. SRL 0xFFFFFFFF by 31 -> 0x00000001. Each has the correct latency.
- Back-to-back SLL 1 by 0,1,2 (tags 0,1,2) with I_ready held 0 for 3 cycles from first O_valid:
  - O_ready drops to 0 and O_result holds at 0x00000001, tag 0.
  - After release, the outputs 0x1, 0x2, 0x4 appear in order on consecutive cycles.
- Amount 0 for all funcs 000..100 on 0xDEADBEEF -> 0xDEADBEEF. Func 111 -> 0x00000000 with O_valid=1.
- Flush with 2 ops in flight -> O_valid=0 and O_busy=0 the next cycle, and no later output. Repeat with I_reset_n pulsed low mid-flight -> outputs 0 immediately.
- WIDTH=8, PIPE_STAGES=3: SRA 0x80 by 7 -> 0xFF. ROR 0x81 by 1 -> 0xC0. Latency is 3 cycles.
